rw_stage: RTL
=============

# rw_stage

Register-write (RW) stage of the five-stage SimpleRISC pipeline, and the writer side of the operand-fetch interface. It latches the instruction leaving the memory-access (MA) stage, selects the writeback value, owns and writes the 16×32 register file, and serves the OF stage's two read ports. It also produces the RW→OF forwarding data and select bits that steer OF's operand muxes.

## Interface
- `NREGS`, 16: register count; register index width is 4.
- `XLEN`, 32: data width.
- `clk`  in  1  clock, all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `ma_valid`  in  1  MA stage holds a real instruction (0 = bubble).
- `ma_pc`  in  32  PC of the MA instruction.
- `ma_inst`  in  32  instruction word.
- `ma_alu_result`  in  32  ALU result.
- `ma_ld_result`  in  32  load data.
- `ma_control_signals`  in  22  control vector from the control unit.
- `read_port1`, `read_port2`  in  4  register indices requested by OF.
- `OP1_input`, `OP2_input`  out  32  register file read data for the ports above.
- `Data_from_rw_for_OF`  out  32  writeback value of the instruction now in RW.
- `signal1_from_forwarding1_for_RW_OF`, `signal2_from_forwarding2_for_RW_OF`  out  1  forward select for port 1 / port 2.
- `instr_count`  out  32  retired valid instructions.

## Operation
- Control bit indices: isSt 0, isLd 1, isBeq 2, isBgt 3, isRet 4, isImmediate 5, isWb 6, isCall 7, ALU op bits 8–21.
- RW latch: on every edge it captures all `ma_*` inputs. `rw_valid` takes the value of `ma_valid`.
- Destination: if isCall, register 15 (ra); otherwise `rw_inst[25:22]`.
- Writeback value:
  - isLd → `rw_ld_result`
  - else isCall → `rw_pc + 4`
  - else → `rw_alu_result`
  - This value drives `Data_from_rw_for_OF` whether or not the instruction is valid.
- Write enable is `rw_valid & isWb`. When it is high, the register file writes the destination on the next rising edge.
- Read ports are asynchronous, indexed by `read_port1`/`read_port2`. They return stored contents only, with no internal bypass.
- Forwarding: `signalN` = `rw_valid & isWb & (read_portN == dest)`. Each port is independent; both may be high at once.
- `instr_count` increments on every edge where `rw_valid` = 1, stores included. It wraps from 0xFFFFFFFF to 0.

## Timing
- Reset state:
  - All registers, the RW latch, `rw_valid` and `instr_count` are 0.
  - Consequently all outputs read 0 and both forward selects are 0.
- Reset asserted mid-operation discards the pending RW write; no register-file write occurs on or after the asserting edge.
- Latency:
  - Instruction in MA at cycle n → in RW at cycle n+1, with `Data_from_rw_for_OF` valid combinationally in n+1.
  - Register-file contents updated at the edge ending n+1.
  - A read in n+2 returns the new value with the forward select low.
- Same-cycle read and write of one register: `OP*_input` returns the old value, the matching forward select is 1, and OF selects `Data_from_rw_for_OF`.
- Bubble (`rw_valid` = 0) or non-writeback instruction: no write, forward selects 0, count unchanged.
- Back-to-back writes to one register: the last write wins, and forwarding always reflects the RW occupant.

## Structure
- The shared package `pipe_pkg` holds the control bit index constants, `RA_REG` = 15 and `XLEN`/`NREGS`. OF and the other stages use the same package.
- Sub-module `rw_regfile`: 16×32, async reset to zero, one synchronous write port, two asynchronous read ports.
- The RW latch, writeback mux, forwarding compare and counter stay in the top module.

## Test plan
- Reset: with the register file previously filled, assert `rst` between edges. Expect all `OP*_input` = 0, `instr_count` = 0 and forward selects 0 immediately, with no clock needed.
- ALU writeback + forward:
  - Stimulus: valid add with rd = 3, alu = 0x12345678, `read_port1` = 3.
  - In RW: `signal1` = 1, `Data_from_rw_for_OF` = 0x12345678, `OP1_input` = old value.
  - Next cycle: `OP1_input` = 0x12345678 and `signal1` = 0.
- Load vs call:
  - Valid ld with rd = 5, `ld_result` = 0xDEADBEEF: r5 = 0xDEADBEEF.
  - Valid call with pc = 0x100: r15 = 0x104; `read_port2` = 15 in RW gives `signal2` = 1.
- No write:
  - A store with isWb = 0 and rd = 2 leaves r2 unchanged with both selects 0.
  - The same instruction with `ma_valid` = 0 leaves r2 unchanged and does not increment `instr_count`.
- Dual forward: both read ports = 7 while a valid writeback targets r7. Expect both selects = 1.
- Counter wrap: preload `instr_count` to 0xFFFFFFFF via the bench hierarchy; one valid instruction gives 0.

Source files
------------

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared pipeline constants: widths, control bit indices, return-address register
package pipe_pkg;

  localparam int XLEN   = 32;
  localparam int NREGS  = 16;
  localparam int REG_W  = 4;
  localparam int CTRL_W = 22;

  // Control vector bit positions; bits 8..21 carry the ALU operation.
  localparam int IS_ST   = 0;
  localparam int IS_LD   = 1;
  localparam int IS_BEQ  = 2;
  localparam int IS_BGT  = 3;
  localparam int IS_RET  = 4;
  localparam int IS_IMM  = 5;
  localparam int IS_WB   = 6;
  localparam int IS_CALL = 7;

  localparam logic [REG_W-1:0] RA_REG = 4'd15;

  // Destination register: calls always link into ra, everything else uses rd.
  function automatic logic [REG_W-1:0] dest_reg(input logic is_call, input logic [XLEN-1:0] inst);
    return is_call ? RA_REG : inst[25:22];
  endfunction

endpackage

// File: rtl/rw_regfile.sv
// rtl/rw_regfile.sv - 16x32 register file, one synchronous write port, two asynchronous read ports
module rw_regfile
  import pipe_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [REG_W-1:0] wr_addr,
  input  logic [XLEN-1:0]  wr_data,
  input  logic [REG_W-1:0] rd_addr1,
  input  logic [REG_W-1:0] rd_addr2,
  output logic [XLEN-1:0]  rd_data1,
  output logic [XLEN-1:0]  rd_data2
);

  logic [XLEN-1:0] regs [NREGS];

  // Storage: cleared on reset, single write per edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // Reads return stored contents only; same-cycle writes are covered by forwarding.
  assign rd_data1 = regs[rd_addr1];
  assign rd_data2 = regs[rd_addr2];

endmodule

// File: rtl/rw_stage.sv
// rtl/rw_stage.sv - register-write pipeline stage with register file and RW-to-OF forwarding
module rw_stage
  import pipe_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              ma_valid,
  input  logic [XLEN-1:0]   ma_pc,
  input  logic [XLEN-1:0]   ma_inst,
  input  logic [XLEN-1:0]   ma_alu_result,
  input  logic [XLEN-1:0]   ma_ld_result,
  input  logic [CTRL_W-1:0] ma_control_signals,
  input  logic [REG_W-1:0]  read_port1,
  input  logic [REG_W-1:0]  read_port2,
  output logic [XLEN-1:0]   OP1_input,
  output logic [XLEN-1:0]   OP2_input,
  output logic [XLEN-1:0]   Data_from_rw_for_OF,
  output logic              signal1_from_forwarding1_for_RW_OF,
  output logic              signal2_from_forwarding2_for_RW_OF,
  output logic [XLEN-1:0]   instr_count
);

  logic              rw_valid;
  logic [XLEN-1:0]   rw_pc;
  logic [XLEN-1:0]   rw_inst;
  logic [XLEN-1:0]   rw_alu_result;
  logic [XLEN-1:0]   rw_ld_result;
  logic [CTRL_W-1:0] rw_ctrl;
  logic [XLEN-1:0]   count_q;

  logic [REG_W-1:0]  dest;
  logic [XLEN-1:0]   wb_data;
  logic              wr_en;

  // RW latch: capture whatever leaves MA each cycle, bubbles included.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rw_valid      <= 1'b0;
      rw_pc         <= '0;
      rw_inst       <= '0;
      rw_alu_result <= '0;
      rw_ld_result  <= '0;
      rw_ctrl       <= '0;
    end else begin
      rw_valid      <= ma_valid;
      rw_pc         <= ma_pc;
      rw_inst       <= ma_inst;
      rw_alu_result <= ma_alu_result;
      rw_ld_result  <= ma_ld_result;
      rw_ctrl       <= ma_control_signals;
    end
  end

  // Writeback value selection: load data beats link address beats ALU result.
  always_comb begin
    wb_data = rw_alu_result;
    if (rw_ctrl[IS_LD]) begin
      wb_data = rw_ld_result;
    end else if (rw_ctrl[IS_CALL]) begin
      wb_data = rw_pc + 32'd4;
    end
  end

  assign dest  = dest_reg(rw_ctrl[IS_CALL], rw_inst);
  assign wr_en = rw_valid & rw_ctrl[IS_WB];

  rw_regfile u_regfile (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_addr  (dest),
    .wr_data  (wb_data),
    .rd_addr1 (read_port1),
    .rd_addr2 (read_port2),
    .rd_data1 (OP1_input),
    .rd_data2 (OP2_input)
  );

  assign Data_from_rw_for_OF                = wb_data;
  assign signal1_from_forwarding1_for_RW_OF = wr_en & (read_port1 == dest);
  assign signal2_from_forwarding2_for_RW_OF = wr_en & (read_port2 == dest);

  // Retired-instruction counter: every valid RW occupant counts, wrapping naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (rw_valid) begin
      count_q <= count_q + 32'd1;
    end
  end

  assign instr_count = count_q;

endmodule
